// File: rtl/hilo_unit.sv
// HI/LO sequencing stage: issues multiplies to the Booth multiplier, applies the
// MULTU correction to its signed product, and commits HI/LO; MTHI/MTLO write directly.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        mul_done
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4
  } op_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          err_q, err_d;
  logic          mul_start_q, mul_start_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          uns_q, uns_d;
  logic [63:0]   p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [63:0]   corr_a, corr_b, p_fix;
  logic          timed_out;

  // Signed product -> unsigned product: add the other operand shifted up by 32
  // for every operand whose sign bit was misread as negative.
  always_comb begin
    corr_a = '0;
    corr_b = '0;
    if (uns_q && mul_a_q[31]) corr_a = {mul_b_q, 32'b0};
    if (uns_q && mul_b_q[31]) corr_b = {mul_a_q, 32'b0};
    p_fix = p_q + corr_a + corr_b;
  end

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    uns_d       = uns_q;
    p_d         = p_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d     = rs;
              mul_b_d     = rt;
              uns_d       = (op == OP_MULTU);
              mul_start_d = 1'b1;
              busy_d      = 1'b1;
              cnt_d       = '0;
              state_d     = S_ARM;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end

      // A done=1 seen here is left over from the previous operation.
      S_ARM: begin
        cnt_d = cnt_q + CW'(1);
        if (timed_out) begin
          err_d       = 1'b1;
          mul_start_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (!mul_done) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_done) begin
          p_d         = mul_z;
          mul_start_d = 1'b0;
          state_d     = S_FIX;
        end else if (timed_out) begin
          err_d       = 1'b1;
          mul_start_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_FIX: begin
        p_d     = p_fix;
        hi_d    = p_fix[63:32];
        lo_d    = p_fix[31:0];
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      uns_q       <= 1'b0;
      p_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      uns_q       <= uns_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign err       = err_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit with a behavioural negedge-sampling multiplier model.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy, err, mul_start;
  logic [31:0] hi, lo, mul_a, mul_b;
  logic [63:0] mul_z;
  logic        mul_done;

  hilo_unit #(.TIMEOUT(120)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .hi(hi), .lo(lo), .err(err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Multiplier model: done=1 out of reset, drops on first negedge with start
  // (optionally after a stale hold), completes after LAT negedges.
  localparam int unsigned LAT = 8;
  int unsigned   stale_cfg  = 0;
  bit            never_drop = 0;
  int unsigned   m_hold, m_cnt;
  bit            m_busy;
  logic signed [63:0] m_sa, m_sb;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mul_done = 1'b1;
      mul_z    = '0;
      m_busy   = 0;
      m_hold   = 0;
      m_cnt    = 0;
    end else if (m_busy) begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) mul_done = 1'b0;
      end else if (m_cnt == LAT - 1) begin
        mul_z    = m_sa * m_sb;
        mul_done = 1'b1;
        m_busy   = 0;
      end else begin
        m_cnt++;
      end
    end else if (mul_start && !never_drop) begin
      m_busy = 1;
      m_cnt  = 0;
      m_hold = stale_cfg;
      m_sa   = {{32{mul_a[31]}}, mul_a};
      m_sb   = {{32{mul_b[31]}}, mul_b};
      if (stale_cfg == 0) mul_done = 1'b0;
    end
  end

  int unsigned starts = 0;
  always @(posedge mul_start) starts++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  bit          mon_en = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_hi = '0, prev_lo = '0;

  // Monitor: an output event is busy falling or HI/LO changing.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && ((prev_busy && !busy) || hi !== prev_hi || lo !== prev_lo)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {hi, lo}, {prev_hi, prev_lo});
      end else begin
        e = exp_q.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("err", {63'b0, err}, {63'b0, e.err});
      end
    end
    prev_busy = busy;
    prev_hi   = hi;
    prev_lo   = lo;
  end

  task automatic expect_out(input logic [31:0] h, input logic [31:0] l, input logic e);
    exp_t x;
    x.hi = h; x.lo = l; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(input string tag, output int unsigned n);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({tag, "_idle_timeout"}, 64'(busy), 64'd0);
  endtask

  int unsigned n;

  initial begin
    reset = 1'b0;
    #23;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_a", 64'(mul_a), 64'd0);
    chk("rst_b", 64'(mul_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1;

    // MULT -1 * 2, with an MTHI issued while busy that must be dropped
    starts = 0;
    expect_out(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
    chk("mult_busy", 64'(busy), 64'd1);
    issue(3'd3, 32'h12345678, 32'h0);
    wait_idle("mult", n);
    repeat (3) @(negedge clk);
    chk("mult_start_once", 64'(starts), 64'd1);

    expect_out(32'h00000001, 32'hFFFFFFFE, 1'b0);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
    wait_idle("multu1", n);

    expect_out(32'h40000000, 32'h00000000, 1'b0);
    issue(3'd2, 32'h80000000, 32'h80000000);
    wait_idle("multu2", n);

    expect_out(32'h40000000, 32'hCAFEBABE, 1'b0);
    issue(3'd4, 32'hCAFEBABE, 32'h0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("mtlo_busy2", 64'(busy), 64'd0);

    issue(3'd7, 32'h11111111, 32'h22222222);
    chk("nop7_busy", 64'(busy), 64'd0);

    // Stale done held for 3 cycles after start
    stale_cfg = 3;
    expect_out(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue(3'd1, 32'h00000007, 32'hFFFFFFFD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stale_busy", 64'(busy), 64'd1);
      chk("stale_start", 64'(mul_start), 64'd1);
    end
    wait_idle("stale", n);
    stale_cfg = 0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a multiply
    issue(3'd1, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    mon_en = 0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_start", 64'(mul_start), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1;

    expect_out(32'h00000000, 32'h0000000F, 1'b0);
    issue(3'd1, 32'd3, 32'd5);
    wait_idle("post_rst", n);
    repeat (2) @(negedge clk);

    // Multiplier never drops done: abort after 120 cycles
    never_drop = 1;
    expect_out(32'h00000000, 32'h0000000F, 1'b1);
    issue(3'd1, 32'd6, 32'd7);
    wait_idle("timeout", n);
    chk("timeout_cycles", 64'(n), 64'd120);
    chk("timeout_start", 64'(mul_start), 64'd0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequencing stage directly downstream of the Booth multiplier in the CPU datapath. Accepts MULT/MULTU/MTHI/MTLO requests from the execute stage, drives the multiplier's start/operand handshake, applies the unsigned correction for MULTU, and commits the 64-bit product into the architectural HI/LO registers. While a multiply is in flight it raises `busy` so the pipeline stalls.

## Interface

Parameters:
- `TIMEOUT`, default 255: posedge cycles allowed in ARM+RUN before abort; must be ≥ 100.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request strobe from execute stage.
- `op`  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5–7 treated as NOP.
- `rs`  in  32  operand A; MTHI/MTLO data.
- `rt`  in  32  operand B.
- `busy`  out  1  multiply in flight; pipeline stall.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `err`  out  1  sticky timeout flag; cleared only by reset.
- `mul_start`  out  1  to multiplier `start`.
- `mul_a`  out  32  to multiplier `a`.
- `mul_b`  out  32  to multiplier `b`.
- `mul_z`  in  64  signed product from multiplier.
- `mul_done`  in  1  multiplier done flag.

## Operation

- Reset values: `busy`=0, `hi`=0, `lo`=0, `err`=0, `mul_start`=0, `mul_a`=0, `mul_b`=0, state IDLE, timeout counter 0.
- Request accepted only when `op_valid`=1 and state IDLE (`busy`=0). Requests while busy are ignored, not queued.
- MTHI: `hi`←`rs` on the accepting edge. MTLO: `lo`←`rs`. Stays IDLE, `busy` stays 0.
- MULT/MULTU accept: latch `rs`→`mul_a`, `rt`→`mul_b`; latch unsigned flag (op==2); `mul_start`←1; `busy`←1; go ARM.
- The multiplier samples on negedge, holds `done`=1 from reset/previous op, drops it on the first negedge with start high, and restarts if start stays high after finishing. Hence:
  - ARM: hold `mul_start`=1; on `mul_done`=0 go RUN. A stale `mul_done`=1 in ARM is never a completion.
  - RUN: hold `mul_start`=1; on `mul_done`=1, register `mul_z` into product register P, drive `mul_start`←0 on that same edge, go FIX.
  - FIX (one cycle): if unsigned, P ← P + (A[31] ? {B,32'b0} : 0) + (B[31] ? {A,32'b0} : 0) mod 2^64; else P unchanged. Commit `hi`←P[63:32], `lo`←P[31:0]; `busy`←0; go IDLE.
- `mul_a`/`mul_b` held stable from accept through FIX.
- Timeout: counter clears on accept and increments each cycle in ARM/RUN. On reaching `TIMEOUT`: `err`←1, `mul_start`←0, `busy`←0, IDLE; HI/LO untouched.
- Reset mid-operation: every register returns to its reset value immediately and asynchronously; no partial HI/LO commit.

## Timing

- MTHI/MTLO: `hi`/`lo` visible the cycle after the accepting edge; zero stall.
- Multiply: `busy` high from the edge after accept through the FIX commit edge. Total ≈ 2 + multiplier latency (≈97 negedges ≈ 98 posedges) cycles.
- `hi`/`lo` change only on the FIX edge or an MTHI/MTLO accept edge.
- A new request can be accepted on the first edge with `busy`=0, i.e. the edge after FIX.
- `mul_start` deasserts at a posedge, half a cycle before the multiplier's next negedge, so the multiplier never restarts.

## Test plan

- MULT with `rs`=0xFFFFFFFF, `rt`=0x00000002 -> after `busy` falls, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; `mul_start` asserted exactly once.
- MULTU with the same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE. MULTU 0x80000000×0x80000000 -> `hi`=0x40000000, `lo`=0.
- MTHI 0x12345678 issued while MULT is busy -> ignored; `hi` holds the product afterward. MTLO 0xCAFEBABE when idle -> `lo`=0xCAFEBABE next cycle, `busy` never high.
- Multiplier model holds `mul_done`=1 for 3 cycles after start -> no commit in ARM; commit only after a done low→high sequence.
- Async reset asserted mid-RUN -> `busy`, `mul_start`, `hi`, `lo`, `err`=0 immediately; the next MULT 3×5 -> `hi`=0, `lo`=15.
- `TIMEOUT`=120, multiplier model never drops `mul_done` -> after 120 cycles `err`=1, `busy`=0, HI/LO unchanged.
